mc_control_unit: RTL and testbench

- Parametrised next-generation multi-cycle MIPS control FSM. It drives the datapath muxes and enables of the multi-cycle CPU top.
- Adds the following over the current controller:
  - bne, addi and jal support;
  - a memory ready/request handshake for variable-latency memory;
  - illegal-opcode trap;
  - cycle and retired-instruction performance counters.
- Sits between the instruction register opcode field and the datapath, replacing the existing controller.

---
 rtl/mc_control_unit.sv | 199 +++++++++++++++++++
 tb/tb_mc_control_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle MIPS control FSM with memory handshake, illegal-opcode trap
// and cycle/retired-instruction counters.
module mc_control_unit #(
    parameter logic HAS_MEM_HS      = 1'b1,
    parameter logic TRAP_ON_ILLEGAL = 1'b1,
    parameter int   CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUop,
    output logic [1:0]       PCSrc,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCWriteCondN,
    output logic [3:0]       state,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC      = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        JAL       = 4'd12,
        TRAP      = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cyc_q, ins_q;
    logic done, mreq, mwr, irw, rwr, pcw, pcwc, pcwcn, ret;

    assign done = mem_ready | ~HAS_MEM_HS;

    always_comb begin
        state_d  = state_q;
        mreq     = 1'b0;
        mwr      = 1'b0;
        irw      = 1'b0;
        rwr      = 1'b0;
        pcw      = 1'b0;
        pcwc     = 1'b0;
        pcwcn    = 1'b0;
        ret      = 1'b0;
        IorD     = 1'b0;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUop    = 2'b00;
        PCSrc    = 2'b00;
        illegal  = 1'b0;
        case (state_q)
            FETCH: begin
                mreq    = 1'b1;
                ALUSrcB = 2'b01;
                irw     = done;
                pcw     = done;
                state_d = done ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_R:          state_d = EXEC;
                    OP_LW, OP_SW:  state_d = MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_ADDI:       state_d = ADDI_EXEC;
                    OP_J:          state_d = JUMP;
                    OP_JAL:        state_d = JAL;
                    default:       state_d = TRAP_ON_ILLEGAL ? TRAP : FETCH;
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mreq    = 1'b1;
                IorD    = 1'b1;
                state_d = done ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                rwr      = 1'b1;
                MemtoReg = 2'b01;
                ret      = 1'b1;
                state_d  = FETCH;
            end
            MEM_WRITE: begin
                mreq    = 1'b1;
                IorD    = 1'b1;
                mwr     = done;
                ret     = done;
                state_d = done ? FETCH : MEM_WRITE;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
                state_d = R_WB;
            end
            R_WB: begin
                rwr     = 1'b1;
                RegDst  = 2'b01;
                ret     = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b01;
                PCSrc   = 2'b01;
                pcwc    = (opcode == OP_BEQ);
                pcwcn   = (opcode == OP_BNE);
                ret     = 1'b1;
                state_d = FETCH;
            end
            JUMP: begin
                PCSrc   = 2'b10;
                pcw     = 1'b1;
                ret     = 1'b1;
                state_d = FETCH;
            end
            ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = ADDI_WB;
            end
            ADDI_WB: begin
                rwr     = 1'b1;
                ret     = 1'b1;
                state_d = FETCH;
            end
            JAL: begin
                rwr      = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                PCSrc    = 2'b10;
                pcw      = 1'b1;
                ret      = 1'b1;
                state_d  = FETCH;
            end
            TRAP:    illegal = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    // strobes are forced low combinationally while reset is held, even though FETCH requests memory
    assign mem_req      = reset & mreq;
    assign MemWrite     = reset & mwr;
    assign IRWrite      = reset & irw;
    assign RegWrite     = reset & rwr;
    assign PCWrite      = reset & pcw;
    assign PCWriteCond  = reset & pcwc;
    assign PCWriteCondN = reset & pcwcn;
    assign retire       = reset & ret;
    assign state        = state_q;
    assign cycle_cnt    = cyc_q;
    assign instr_cnt    = ins_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            cyc_q   <= '0;
            ins_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != TRAP) cyc_q <= cyc_q + CNT_W'(1);
            if (ret) ins_q <= ins_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: randomized scoreboard bench for two controller configurations
// (handshake+trap with 32-bit counters, and no-handshake+NOP-on-illegal with 4-bit counters).
module tb_mc_control_unit;
    localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [5:0] ADDI = 6'h08, J = 6'h02, JAL = 6'h03, ILL = 6'h3f;
    localparam logic [20:0] STROBES = 21'h17001E;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic [5:0] op;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a, reset_b, mem_ready_a, mem_ready_b;
    logic [5:0] opcode_a, opcode_b;
    logic mem_req_a, IorD_a, MemWrite_a, IRWrite_a, RegWrite_a, ALUSrcA_a, PCWrite_a;
    logic PCWriteCond_a, PCWriteCondN_a, retire_a, illegal_a;
    logic [1:0] RegDst_a, MemtoReg_a, ALUSrcB_a, ALUop_a, PCSrc_a;
    logic [3:0] state_a;
    logic [31:0] cycle_cnt_a, instr_cnt_a;
    logic mem_req_b, IorD_b, MemWrite_b, IRWrite_b, RegWrite_b, ALUSrcA_b, PCWrite_b;
    logic PCWriteCond_b, PCWriteCondN_b, retire_b, illegal_b;
    logic [1:0] RegDst_b, MemtoReg_b, ALUSrcB_b, ALUop_b, PCSrc_b;
    logic [3:0] state_b;
    logic [3:0] cycle_cnt_b, instr_cnt_b;

    mc_control_unit dut_a (
        .clk(clk), .reset(reset_a), .opcode(opcode_a), .mem_ready(mem_ready_a),
        .mem_req(mem_req_a), .IorD(IorD_a), .MemWrite(MemWrite_a), .IRWrite(IRWrite_a),
        .RegWrite(RegWrite_a), .RegDst(RegDst_a), .MemtoReg(MemtoReg_a), .ALUSrcA(ALUSrcA_a),
        .ALUSrcB(ALUSrcB_a), .ALUop(ALUop_a), .PCSrc(PCSrc_a), .PCWrite(PCWrite_a),
        .PCWriteCond(PCWriteCond_a), .PCWriteCondN(PCWriteCondN_a), .state(state_a),
        .retire(retire_a), .illegal(illegal_a), .cycle_cnt(cycle_cnt_a), .instr_cnt(instr_cnt_a)
    );

    mc_control_unit #(.HAS_MEM_HS(1'b0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset_b), .opcode(opcode_b), .mem_ready(mem_ready_b),
        .mem_req(mem_req_b), .IorD(IorD_b), .MemWrite(MemWrite_b), .IRWrite(IRWrite_b),
        .RegWrite(RegWrite_b), .RegDst(RegDst_b), .MemtoReg(MemtoReg_b), .ALUSrcA(ALUSrcA_b),
        .ALUSrcB(ALUSrcB_b), .ALUop(ALUop_b), .PCSrc(PCSrc_b), .PCWrite(PCWrite_b),
        .PCWriteCond(PCWriteCond_b), .PCWriteCondN(PCWriteCondN_b), .state(state_b),
        .retire(retire_b), .illegal(illegal_b), .cycle_cnt(cycle_cnt_b), .instr_cnt(instr_cnt_b)
    );

    logic [20:0] act_a, act_b;
    assign act_a = {mem_req_a, IorD_a, MemWrite_a, IRWrite_a, RegWrite_a, RegDst_a, MemtoReg_a,
                    ALUSrcA_a, ALUSrcB_a, ALUop_a, PCSrc_a, PCWrite_a, PCWriteCond_a,
                    PCWriteCondN_a, retire_a, illegal_a};
    assign act_b = {mem_req_b, IorD_b, MemWrite_b, IRWrite_b, RegWrite_b, RegDst_b, MemtoReg_b,
                    ALUSrcA_b, ALUSrcB_b, ALUop_b, PCSrc_b, PCWrite_b, PCWriteCond_b,
                    PCWriteCondN_b, retire_b, illegal_b};

    rec_t qa[$], qb[$];
    int checks = 0, errors = 0;
    logic [31:0] cma, ima;
    logic [3:0] cmb, imb;
    logic [5:0] ops_a [8] = '{LW, SW, R, ADDI, BEQ, BNE, J, JAL};
    logic [5:0] ops_b [10] = '{LW, SW, R, ADDI, BEQ, BNE, J, JAL, ILL, 6'h11};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic rec_t mk(input int st, input logic rdy, input logic [5:0] op);
        rec_t r;
        r.st = 4'(st);
        r.rdy = rdy;
        r.op = op;
        return r;
    endfunction

    // Expected control vector for one cycle, straight from the per-state output table
    function automatic logic [20:0] ctrl(input rec_t r, input logic hs);
        logic done, mr, iord, mw, irw, rw, sa, pw, pwc, pwcn, ret, ill;
        logic [1:0] rd, mtr, sb, aop, pcs;
        done = r.rdy | !hs;
        {mr, iord, mw, irw, rw, sa, pw, pwc, pwcn, ret, ill} = '0;
        {rd, mtr, sb, aop, pcs} = '0;
        case (r.st)
            4'd0:  begin mr = 1; sb = 2'b01; irw = done; pw = done; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin mr = 1; iord = 1; end
            4'd4:  begin rw = 1; mtr = 2'b01; ret = 1; end
            4'd5:  begin mr = 1; iord = 1; mw = done; ret = done; end
            4'd6:  begin sa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 2'b01; ret = 1; end
            4'd8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; pwc = (r.op == BEQ); pwcn = (r.op == BNE); ret = 1; end
            4'd9:  begin pcs = 2'b10; pw = 1; ret = 1; end
            4'd10: begin sa = 1; sb = 2'b10; end
            4'd11: begin rw = 1; ret = 1; end
            4'd12: begin rw = 1; rd = 2'b10; mtr = 2'b10; pcs = 2'b10; pw = 1; ret = 1; end
            4'd15: ill = 1;
            default: ;
        endcase
        return {mr, iord, mw, irw, rw, rd, mtr, sa, sb, aop, pcs, pw, pwc, pwcn, ret, ill};
    endfunction

    task automatic step(input logic sel, input rec_t r);
        if (sel) begin
            opcode_b = r.op; mem_ready_b = r.rdy; qb.push_back(r);
        end else begin
            opcode_a = r.op; mem_ready_a = r.rdy; qa.push_back(r);
        end
        @(posedge clk); #1;
    endtask

    // Builds the cycle-by-cycle state timeline of one instruction from its latency rules,
    // then drives it (at most lim cycles) and queues the expectations.
    task automatic play(input logic sel, input logic [5:0] op, input int wf, input int wm, input int lim);
        rec_t s[$];
        logic hs;
        hs = !sel;
        if (!hs) begin wf = 0; wm = 0; end
        repeat (wf) s.push_back(mk(0, 1'b0, op));
        s.push_back(mk(0, hs ? 1'b1 : rb(), op));
        s.push_back(mk(1, rb(), op));
        case (op)
            LW: begin
                s.push_back(mk(2, rb(), op));
                repeat (wm) s.push_back(mk(3, 1'b0, op));
                s.push_back(mk(3, hs ? 1'b1 : rb(), op));
                s.push_back(mk(4, rb(), op));
            end
            SW: begin
                s.push_back(mk(2, rb(), op));
                repeat (wm) s.push_back(mk(5, 1'b0, op));
                s.push_back(mk(5, hs ? 1'b1 : rb(), op));
            end
            R:        begin s.push_back(mk(6, rb(), op)); s.push_back(mk(7, rb(), op)); end
            ADDI:     begin s.push_back(mk(10, rb(), op)); s.push_back(mk(11, rb(), op)); end
            BEQ, BNE: s.push_back(mk(8, rb(), op));
            J:        s.push_back(mk(9, rb(), op));
            JAL:      s.push_back(mk(12, rb(), op));
            default:  if (!sel) repeat (4) s.push_back(mk(15, rb(), op));
        endcase
        foreach (s[i]) if (i < lim) step(sel, s[i]);
    endtask

    task automatic do_reset(input logic sel);
        string p;
        p = sel ? "b" : "a";
        if (sel) begin mem_ready_b = 1'b1; reset_b = 1'b0; end
        else begin mem_ready_a = 1'b1; reset_a = 1'b0; end
        #1;
        chk({p, "_rst_state"}, sel ? 32'(state_b) : 32'(state_a), 32'd0);
        chk({p, "_rst_cycle"}, sel ? 32'(cycle_cnt_b) : cycle_cnt_a, 32'd0);
        chk({p, "_rst_instr"}, sel ? 32'(instr_cnt_b) : instr_cnt_a, 32'd0);
        chk({p, "_rst_strobes"}, 32'((sel ? act_b : act_a) & STROBES), 32'd0);
        @(posedge clk); #1;
        chk({p, "_rst_hold_strobes"}, 32'((sel ? act_b : act_a) & STROBES), 32'd0);
        chk({p, "_rst_hold_cycle"}, sel ? 32'(cycle_cnt_b) : cycle_cnt_a, 32'd0);
        if (sel) reset_b = 1'b1; else reset_a = 1'b1;
    endtask

    initial forever begin
        rec_t r;
        logic [20:0] e;
        @(negedge clk);
        if (!reset_a) begin
            cma = 0; ima = 0;
        end else if (qa.size() != 0) begin
            r = qa.pop_front();
            e = ctrl(r, 1'b1);
            chk("a_state", 32'(state_a), 32'(r.st));
            chk("a_ctrl", 32'(act_a), 32'(e));
            chk("a_cycle_cnt", cycle_cnt_a, cma);
            chk("a_instr_cnt", instr_cnt_a, ima);
            if (r.st != 4'd15) cma = cma + 1;
            if (e[1]) ima = ima + 1;
        end
    end

    initial forever begin
        rec_t r;
        logic [20:0] e;
        @(negedge clk);
        if (!reset_b) begin
            cmb = 0; imb = 0;
        end else if (qb.size() != 0) begin
            r = qb.pop_front();
            e = ctrl(r, 1'b0);
            chk("b_state", 32'(state_b), 32'(r.st));
            chk("b_ctrl", 32'(act_b), 32'(e));
            chk("b_cycle_cnt", 32'(cycle_cnt_b), 32'(cmb));
            chk("b_instr_cnt", 32'(instr_cnt_b), 32'(imb));
            if (r.st != 4'd15) cmb = cmb + 1'b1;
            if (e[1]) imb = imb + 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_a = 0; reset_b = 0; mem_ready_a = 0; mem_ready_b = 0; opcode_a = 0; opcode_b = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_a = 1; reset_b = 1;
        fork
            begin
                play(0, LW, 3, 0, 99);
                play(0, LW, 0, 0, 99);
                play(0, SW, 0, 2, 99);
                play(0, BNE, 1, 0, 99);
                play(0, BEQ, 0, 0, 99);
                play(0, JAL, 0, 0, 99);
                play(0, R, 2, 0, 99);
                play(0, ADDI, 0, 0, 99);
                play(0, J, 0, 0, 99);
                repeat (60) play(0, ops_a[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 2), 99);
                play(0, LW, 1, 1, 4);
                do_reset(0);
                play(0, SW, 0, 1, 99);
                play(0, ILL, 0, 0, 99);
                do_reset(0);
                play(0, R, 0, 0, 99);
            end
            begin
                repeat (50) play(1, ops_b[$urandom_range(0, 9)], 0, 0, 99);
                play(1, ADDI, 0, 0, 2);
                do_reset(1);
                play(1, JAL, 0, 0, 99);
                play(1, ILL, 0, 0, 99);
                play(1, R, 0, 0, 99);
            end
        join
        @(negedge clk);
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
